// File: rtl/program_counting_system_if.sv
// Control-unit to program-counter bus: select/write strobes in, PC/PC_1/RA out.
interface program_counting_system_if;
   logic        restore;
   logic        writePC;
   logic        writeRA;
   logic        PCsrc;
   logic        ImRPC;
   logic        conditionalBop;
   logic [15:0] ImR;
   logic [15:0] PC;
   logic [15:0] PC_1;
   logic [15:0] RA;

   modport master (
      output restore, writePC, writeRA, PCsrc, ImRPC, conditionalBop, ImR,
      input  PC, PC_1, RA
   );

   modport slave (
      input  restore, writePC, writeRA, PCsrc, ImRPC, conditionalBop, ImR,
      output PC, PC_1, RA
   );
endinterface

// File: rtl/program_counting_system.sv
// Program counter with return-address register and next-PC selection.
// Optional PREV shadow register and restore path enabled by PCS_RESTORE_EN.
module program_counting_system (
   input  logic                            clk,
   input  logic                            rst_n,
   program_counting_system_if.slave        bus
);
   logic        [15:0] pc;
   logic        [15:0] ra;
   logic        [15:0] pc_1;
   logic        [15:0] pc_next;
   logic signed [15:0] offset;

   // Two's-complement offset add; the carry out of bit 15 is dropped.
   function automatic logic [15:0] add_wrap(input logic [15:0] base,
                                            input logic signed [15:0] delta);
      add_wrap = base + $unsigned(delta);
   endfunction

   assign offset = bus.ImR;
   assign pc_1   = add_wrap(pc, 16'sd1);

   always_comb begin
      pc_next = pc_1;
      if (bus.PCsrc)
         pc_next = ra;
      else if (bus.ImRPC)
         pc_next = bus.ImR;
      else if (bus.conditionalBop)
         pc_next = add_wrap(pc, offset);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ra <= 16'h0000;
      else if (bus.writeRA)
         ra <= pc_1;
   end

`ifdef PCS_RESTORE_EN
   logic [15:0] prev;

   // restore wins over writePC and leaves the shadow copy intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc   <= 16'h0000;
         prev <= 16'h0000;
      end else if (bus.restore) begin
         pc   <= prev;
      end else if (bus.writePC) begin
         pc   <= pc_next;
         prev <= pc;
      end
   end
`else
   logic unused_restore;
   assign unused_restore = bus.restore;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= 16'h0000;
      else if (bus.writePC)
         pc <= pc_next;
   end
`endif

   assign bus.PC   = pc;
   assign bus.PC_1 = pc_1;
   assign bus.RA   = ra;
endmodule

// File: tb/tb_program_counting_system.sv
// Self-checking bench for program_counting_system: directed plan plus random strobes vs. an arithmetic model.
module tb_program_counting_system;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   program_counting_system_if bus();
   program_counting_system dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef PCS_RESTORE_EN
   localparam bit RESTORE_EN = 1'b1;
`else
   localparam bit RESTORE_EN = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   int m_pc, m_ra, m_prev;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input bit rs, input bit wpc, input bit wra, input bit src,
                        input bit imj, input bit bop, input logic [15:0] imr);
      bus.restore = rs; bus.writePC = wpc; bus.writeRA = wra;
      bus.PCsrc = src; bus.ImRPC = imj; bus.conditionalBop = bop; bus.ImR = imr;
   endtask

   task automatic check_state(input string tag);
      logic [15:0] e_pc, e_ra, e_pc1;
      e_pc  = m_pc[15:0];
      e_ra  = m_ra[15:0];
      e_pc1 = 16'((m_pc + 1) % 65536);
      check_val({tag, "_pc"}, bus.PC, e_pc);
      check_val({tag, "_ra"}, bus.RA, e_ra);
      check_val({tag, "_pc1"}, bus.PC_1, e_pc1);
   endtask

   // One clock: drive strobes, check PC_1 before the edge, advance model, check after edge.
   task automatic step(input bit rs, input bit wpc, input bit wra, input bit src,
                       input bit imj, input bit bop, input logic [15:0] imr);
      int inc, tgt;
      drive(rs, wpc, wra, src, imj, bop, imr);
      #1;
      inc = (m_pc + 1) % 65536;
      check_val("pre_edge_pc1", bus.PC_1, 16'(inc));
      @(posedge clk);
      if (wpc) begin
         if (src)      tgt = m_ra;
         else if (imj) tgt = int'(imr);
         else if (bop) tgt = (m_pc + int'(imr)) % 65536;
         else          tgt = inc;
      end else begin
         tgt = m_pc;
      end
      if (RESTORE_EN && rs) begin
         tgt = m_prev;
      end else if (wpc) begin
         m_prev = m_pc;
      end
      if (wra) m_ra = inc;
      m_pc = tgt;
      #1;
      check_state("step");
   endtask

   task automatic inc_pc();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic jump(input logic [15:0] t);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, t);
   endtask

   // Assert reset between edges with a jump pending; outputs must clear without a clock.
   task automatic mid_reset();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h1234 + $urandom_range(0, 255)));
      #2;
      rst_n = 1'b0;
      m_pc = 0; m_ra = 0; m_prev = 0;
      #1;
      check_state("async_rst");
      @(posedge clk);
      #1;
      check_state("rst_hold");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("rst_release");
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      m_pc = 0; m_ra = 0; m_prev = 0;
      #2 rst_n = 1'b0;
      #1;
      check_val("reset_pc", bus.PC, 16'h0000);
      check_val("reset_ra", bus.RA, 16'h0000);
      check_val("reset_pc1", bus.PC_1, 16'h0001);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state("post_reset");

      repeat (5) inc_pc();
      check_val("seq_pc", bus.PC, 16'd5);
      check_val("seq_pc1", bus.PC_1, 16'd6);
      check_val("seq_ra", bus.RA, 16'd0);

      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd22);
      check_val("call22_pc", bus.PC, 16'd22);
      check_val("call22_ra", bus.RA, 16'd6);
      inc_pc();
      inc_pc();
      check_val("callee_pc", bus.PC, 16'd24);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      check_val("ret22_pc", bus.PC, 16'd6);

      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4096);
      check_val("call4096_pc", bus.PC, 16'd4096);
      check_val("call4096_ra", bus.RA, 16'd7);
      inc_pc();
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      check_val("ret4096_pc", bus.PC, 16'd7);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd349);
      check_val("call349_ra", bus.RA, 16'd8);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      check_val("ret349_pc", bus.PC, 16'd8);

      jump(16'd10);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE);
      check_val("branch_back", bus.PC, 16'd8);
      jump(16'd10);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
      check_val("branch_fwd", bus.PC, 16'd13);
      jump(16'd10);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0030);
      check_val("imrpc_over_bop", bus.PC, 16'h0030);

      // Swap: return and link in the same cycle.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      check_val("swap_pc", bus.PC, 16'd8);
      check_val("swap_ra", bus.RA, 16'h0031);

      jump(16'hFFFF);
      check_val("wrap_pc1", bus.PC_1, 16'h0000);
      inc_pc();
      check_val("wrap_pc", bus.PC, 16'h0000);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom));
      check_val("hold_pc", bus.PC, 16'h0000);

      jump(16'd40);
      jump(16'd100);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef PCS_RESTORE_EN
      check_val("restore_pc", bus.PC, 16'd40);
`else
      check_val("restore_ignored_pc", bus.PC, 16'd100);
`endif

      mid_reset();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            mid_reset();
         end else begin
            step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                 16'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
